uart_tx_framer: RTL and testbench
=================================

// Module: uart_tx_framer
// PURPOSE
//  Serialises one byte per request onto the UART TX line as an 8N1 frame (optional even parity).
//  Sits directly downstream of the button debouncer: its debounced output drives `start`,
//  and each accepted rising edge sends the byte presented on `data_in`.
//  Contains an internal baud-period counter; no external baud tick is needed.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock frequency, Hz
//  BAUD       9600         line rate, bit/s; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), must be >= 2
//  DATA_BITS  8            payload bits per frame, 5..8, sent LSB first
// PORTS
//  clk        in   1          system clock, rising edge
//  reset      in   1          asynchronous, active-high reset
//  start      in   1          request, level from the debouncer; a rising edge seen in IDLE starts a frame
//  data_in    in   DATA_BITS  payload; sampled only on the accepting edge
//  tx         out  1          serial line, idle high
//  busy       out  1          high from the accepting edge until the stop bit completes
//  done       out  1          one-cycle pulse after the stop bit completes
// BEHAVIOUR
//  Reset (async): tx=1, busy=0, done=0, state=IDLE, start_q=0, counters=0, shift reg=0.
//  Edge detect: start_q <= start every cycle; req = start & ~start_q.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE. All outputs are registered.
//   IDLE:   tx=1. On req: latch data_in into the shift reg, busy<=1, tx<=0, baud_cnt<=0, go to START.
//           tx falls one cycle after `start` is sampled high.
//   START:  tx=0 for CLKS_PER_BIT cycles.
//   DATA:   tx=shift[0]; shift right once per bit; bit_idx counts 0..DATA_BITS-1.
//   PARITY: tx = ^payload (even parity); present only with the macro.
//   STOP:   tx=1 for CLKS_PER_BIT cycles. Then busy<=0, done<=1 for one cycle, go to IDLE.
//  Baud counter: width $clog2(CLKS_PER_BIT); counts 0..CLKS_PER_BIT-1; bit_end when ==CLKS_PER_BIT-1.
//   Wraps to 0 at bit_end.
//  Frame length from tx falling edge: (2+DATA_BITS[+1]) * CLKS_PER_BIT cycles exactly.
//  Requests while busy: ignored, not queued. start_q still tracks, so the edge is consumed.
//  start held high: one frame only; start must drop and rise again to retrigger.
//   An alternating debouncer output retriggers only on an edge seen in IDLE.
//  Back-to-back: a req in the cycle done=1 (state IDLE) is accepted; no dead cycle is required.
//  data_in changes after acceptance do not affect the frame in flight.
//  Reset mid-frame: tx returns high immediately (async) and the frame is aborted; no done pulse.
// CONFIGURATION
//  UART_TX_PARITY_EN defined: even parity bit inserted between DATA and STOP; frame = 3+DATA_BITS bits.
//  Undefined: no PARITY state and no parity logic; frame = 2+DATA_BITS bits (8N1 at default).
// STRUCTURE
//  Package uart_pkg: tx state encoding (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, 3-bit),
//   TX_IDLE_LEVEL=1'b1, and the clks_per_bit(CLK_FREQ,BAUD) constant function.
//  One sub-module: uart_baud_counter (clk, reset, clear, bit_end), parameter CLKS_PER_BIT.
//   It is reused later by the RX side.
// TESTING  (bench uses CLK_FREQ=16, BAUD=1 -> CLKS_PER_BIT=16)
//  1 Reset: assert reset mid-cycle -> tx=1, busy=0, done=0 immediately; remain so 20 cycles after release with start=0.
//  2 Basic frame: data_in=8'hA5, pulse start -> tx low next cycle; bits 1,0,1,0,0,1,0,1 each 16 cycles;
//    stop high; busy high 160 cycles; done one cycle.
//  3 start held high 400 cycles, data_in=8'h3C -> exactly one frame and one done pulse.
//  4 Second edge 50 cycles into a frame with data_in=8'hFF -> in-flight frame unchanged; no extra frame follows.
//  5 Back-to-back: new edge during the done cycle, data 8'h00 then 8'h81 -> second start bit begins the next cycle.
//  6 UART_TX_PARITY_EN: data 8'h07 -> parity bit=1 after data; 8'h03 -> 0; busy spans 176 cycles.
//  7 Reset at cycle 70 of a frame -> tx=1 at once, busy=0, no done; next edge sends a clean full frame.

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module     : uart_pkg
// Description: Shared UART types and constants: TX state encoding, idle line
//              level and the clocks-per-bit helper.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_counter.sv
// ============================================================================
// Module     : uart_baud_counter
// Description: Free-running bit-period counter; bit_end marks the last clock
//              of each bit period. clear holds the count at zero.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int               CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_end = (cnt == LAST);

endmodule

`default_nettype wire

// File: rtl/uart_tx_framer.sv
// ============================================================================
// Module     : uart_tx_framer
// Description: Sends one LSB-first UART frame per rising edge of start.
//              Define UART_TX_PARITY_EN to insert an even parity bit.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_framer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int               IDX_W        = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(DATA_BITS - 1);

    tx_state_t            state, state_nx;
    logic                 start_q;
    logic                 req;
    logic                 bit_end;
    logic                 baud_clear;
    logic [DATA_BITS-1:0] shift, shift_nx;
    logic [IDX_W-1:0]     bit_idx, bit_idx_nx;
    logic                 tx_nx, busy_nx, done_nx;
`ifdef UART_TX_PARITY_EN
    logic                 parity, parity_nx;
`endif

    // Edges arriving while busy are swallowed here because start_q always tracks.
    assign req        = start & ~start_q;
    assign baud_clear = (state == IDLE);

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= TX_IDLE_LEVEL;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            start_q <= start;
            shift   <= shift_nx;
            bit_idx <= bit_idx_nx;
            tx      <= tx_nx;
            busy    <= busy_nx;
            done    <= done_nx;
`ifdef UART_TX_PARITY_EN
            parity  <= parity_nx;
`endif
        end
    end

    always_comb begin
        state_nx   = state;
        shift_nx   = shift;
        bit_idx_nx = bit_idx;
        tx_nx      = tx;
        busy_nx    = busy;
        done_nx    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_nx  = parity;
`endif
        case (state)
            IDLE: begin
                tx_nx = TX_IDLE_LEVEL;
                if (req) begin
                    shift_nx  = data_in;
`ifdef UART_TX_PARITY_EN
                    parity_nx = ^data_in;
`endif
                    busy_nx   = 1'b1;
                    tx_nx     = 1'b0;
                    state_nx  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_nx      = shift[0];
                    shift_nx   = shift >> 1;
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx == LAST_IDX) begin
`ifdef UART_TX_PARITY_EN
                        tx_nx    = parity;
                        state_nx = PARITY;
`else
                        tx_nx    = TX_IDLE_LEVEL;
                        state_nx = STOP;
`endif
                    end else begin
                        tx_nx      = shift[0];
                        shift_nx   = shift >> 1;
                        bit_idx_nx = bit_idx + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_nx    = TX_IDLE_LEVEL;
                    state_nx = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    busy_nx  = 1'b0;
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: begin
                tx_nx    = TX_IDLE_LEVEL;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_framer.sv
// ============================================================================
// Module     : tb_uart_tx_framer
// Description: Directed self-checking bench for uart_tx_framer at 16 clocks
//              per bit. Parity cases run when UART_TX_PARITY_EN is defined.
// Revision   : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_framer;

    localparam int CPB = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       start   = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       tx;
    logic       busy;
    logic       done;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    uart_tx_framer #(
        .CLK_FREQ  (16),
        .BAUD      (1),
        .DATA_BITS (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start and confirm the line drops on the very next clock.
    task automatic accept(input string tag, input logic [7:0] d);
        start   = 1'b1;
        data_in = d;
        tick();
        check_eq({tag, ".tx_low"}, int'(tx), 0);
        check_eq({tag, ".busy_set"}, int'(busy), 1);
    endtask

    // Follows an accepted frame cycle by cycle; returns at the done sample.
    task automatic frame_check(input string tag, input logic [7:0] d,
                               input bit hold, input int glitch_at);
        logic [10:0] fr;
        int bad  = 0;
        int bcnt = 0;
        int dcnt = 0;
        fr    = '1;
        fr[0] = 1'b0;
        for (int j = 0; j < 8; j++) fr[j+1] = d[j];
`ifdef UART_TX_PARITY_EN
        fr[9] = ^d;
`endif
        for (int i = 0; i < FRAME; i++) begin
            if (i == 0) begin
                data_in = ~d;
                if (!hold) start = 1'b0;
            end
            if (i == glitch_at) begin
                start   = 1'b1;
                data_in = 8'hFF;
            end
            if (glitch_at >= 0 && i == glitch_at + 1) start = 1'b0;
            if (tx !== fr[i / CPB]) bad++;
            if (busy) bcnt++;
            if (done) dcnt++;
            tick();
        end
        check_eq({tag, ".bit_errs"}, bad, 0);
        check_eq({tag, ".busy_len"}, bcnt, FRAME);
        check_eq({tag, ".early_done"}, dcnt, 0);
        check_eq({tag, ".done"}, int'(done), 1);
        check_eq({tag, ".busy_clr"}, int'(busy), 0);
        check_eq({tag, ".tx_idle"}, int'(tx), 1);
    endtask

    initial begin
        int bad;

        // Reset behaviour
        repeat (3) tick();
        check_eq("rst.tx", int'(tx), 1);
        check_eq("rst.busy", int'(busy), 0);
        check_eq("rst.done", int'(done), 0);
        reset = 1'b0;
        repeat (5) tick();
        #2 reset = 1'b1;
        #1;
        check_eq("rst.async_tx", int'(tx), 1);
        check_eq("rst.async_busy", int'(busy), 0);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
            tick();
        end
        check_eq("rst.quiet", bad, 0);

        // Basic frame 8'hA5
        check_eq("a5.pre_idle", int'(tx), 1);
        accept("a5", 8'hA5);
        frame_check("a5", 8'hA5, 1'b0, -1);
        tick();
        check_eq("a5.done_one_cycle", int'(done), 0);

        // start held high for 400 cycles
        repeat (4) tick();
        accept("hold", 8'h3C);
        frame_check("hold", 8'h3C, 1'b1, -1);
        bad = 0;
        for (int i = 0; i < 400 - FRAME - 1; i++) begin
            tick();
            if (busy || done || tx !== 1'b1) bad++;
        end
        check_eq("hold.no_refire", bad, 0);
        start = 1'b0;
        repeat (3) tick();

        // Edge while busy is ignored, data change ignored
        accept("glitch", 8'h5A);
        frame_check("glitch", 8'h5A, 1'b0, 50);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy || done || tx !== 1'b1) bad++;
        end
        check_eq("glitch.no_queue", bad, 0);

        // Back-to-back: second edge in the done cycle
        accept("b2b0", 8'h00);
        frame_check("b2b0", 8'h00, 1'b0, -1);
        accept("b2b1", 8'h81);
        frame_check("b2b1", 8'h81, 1'b0, -1);
        repeat (3) tick();

`ifdef UART_TX_PARITY_EN
        accept("par07", 8'h07);
        frame_check("par07", 8'h07, 1'b0, -1);
        repeat (3) tick();
        accept("par03", 8'h03);
        frame_check("par03", 8'h03, 1'b0, -1);
        repeat (3) tick();
`endif

        // Reset 70 cycles into a frame
        accept("abort", 8'hC3);
        start = 1'b0;
        repeat (69) tick();
        #2 reset = 1'b1;
        #1;
        check_eq("abort.tx", int'(tx), 1);
        check_eq("abort.busy", int'(busy), 0);
        check_eq("abort.done", int'(done), 0);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy || done || tx !== 1'b1) bad++;
            tick();
        end
        check_eq("abort.quiet", bad, 0);
        accept("post", 8'h96);
        frame_check("post", 8'h96, 1'b0, -1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

`default_nettype wire
